ifetch_prefetch_queue: RTL and testbench

IFETCH_PREFETCH_QUEUE -- requirements
Module: ifetch_prefetch_queue

---
 rtl/ifetch_prefetch_queue.sv | 145 ++++++++++++++
 tb/tb_ifetch_prefetch_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: keeps a single memory read in flight and buffers returned words with pc+4.
// Optional macro PREFETCH_BYPASS_EN forwards an ack straight to the head outputs when the queue is empty.
module ifetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_plus_4,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc4_mem_q  [DEPTH];

  logic        empty, push, pop;
  logic [31:0] addr_plus_4;

  assign empty       = (count_q == '0);
  assign addr_plus_4 = req_addr_q + 32'd4;
  assign pop         = !redirect && deq && !empty;

`ifdef PREFETCH_BYPASS_EN
  logic bypass;
  assign bypass = empty && (state_q == WAIT) && mem_ack && !redirect;
  // A bypassed word taken by the consumer this cycle never enters storage.
  assign push   = (state_q == WAIT) && mem_ack && !redirect && !(bypass && deq);
`else
  assign push   = (state_q == WAIT) && mem_ack && !redirect;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;

    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc & ~32'h3;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end

    // Outside IDLE the in-flight request already holds one slot, so the
    // next-cycle count decides whether another request fits.
    unique case (state_q)
      IDLE: begin
        if (!redirect && (count_q < DEPTH_C)) begin
          state_d    = WAIT;
          req_addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          if (redirect) begin
            state_d = IDLE;
          end else begin
            fetch_pc_d = addr_plus_4;
            if (count_d < DEPTH_C) begin
              state_d    = WAIT;
              req_addr_d = addr_plus_4;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= mem_rdata;
      pc4_mem_q[wr_ptr_q]  <= addr_plus_4;
    end
  end

  assign mem_req  = (state_q != IDLE);
  assign mem_addr = req_addr_q;

  // Storage is not reset; gating on empty gives zeroed head outputs after reset.
  always_comb begin
    inst_valid     = !empty;
    inst_out       = empty ? '0 : inst_mem_q[rd_ptr_q];
    inst_pc_plus_4 = empty ? '0 : pc4_mem_q[rd_ptr_q];
`ifdef PREFETCH_BYPASS_EN
    if (bypass) begin
      inst_valid     = 1'b1;
      inst_out       = mem_rdata;
      inst_pc_plus_4 = addr_plus_4;
    end
`endif
  end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Directed self-checking bench for ifetch_prefetch_queue; memory acks are driven by hand per cycle.
// Honours PREFETCH_BYPASS_EN for the empty-queue bypass expectations.
module tb_ifetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_plus_4;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  ifetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .deq            (deq),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc_plus_4 (inst_pc_plus_4),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; deq = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_out",   inst_out, 32'h0);
    chk("rst_pc4",   inst_pc_plus_4, 32'h0);

    // Fill at 1-cycle ack latency
    reset = 1'b0;
    tick();
    chk("first_req",  32'(mem_req), 32'd1);
    chk("first_addr", mem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1; mem_rdata = 32'hD000_0000 | 32'(i * 4);
      tick();
      if (i < 3) begin
        chk("fill_req",  32'(mem_req), 32'd1);
        chk("fill_addr", mem_addr, 32'((i + 1) * 4));
      end else begin
        chk("full_req", 32'(mem_req), 32'd0);
      end
    end
    mem_ack = 1'b0;
    chk("full_valid", 32'(inst_valid), 32'd1);
    chk("full_head",  inst_out, 32'hD000_0000);
    chk("full_pc4",   inst_pc_plus_4, 32'h4);
    tick();
    chk("full_hold", 32'(mem_req), 32'd0);

    // One deq on a full queue
    deq = 1'b1;
    tick();
    deq = 1'b0;
    chk("deq_head", inst_out, 32'hD000_0004);
    chk("deq_pc4",  inst_pc_plus_4, 32'h8);
    chk("deq_req0", 32'(mem_req), 32'd0);
    tick();
    chk("refill_req",  32'(mem_req), 32'd1);
    chk("refill_addr", mem_addr, 32'h10);

    // Redirect with same-cycle ack; low pc bits forced to zero
    redirect = 1'b1; redirect_pc = 32'h43; mem_ack = 1'b1; mem_rdata = 32'hDEAD_0010;
    tick();
    redirect = 1'b0; mem_ack = 1'b0;
    chk("rdack_valid", 32'(inst_valid), 32'd0);
    chk("rdack_req",   32'(mem_req), 32'd0);
    tick();
    chk("rdack_req2", 32'(mem_req), 32'd1);
    chk("rdack_addr", mem_addr, 32'h40);

    // Asynchronous reset mid-WAIT, then a stale ack
    reset = 1'b1;
    #1;
    chk("arst_req",   32'(mem_req), 32'd0);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_out",   inst_out, 32'h0);
    chk("arst_pc4",   inst_pc_plus_4, 32'h0);
    tick();
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBADB_AD00;
    tick();
    mem_ack = 1'b0;
    chk("stale_valid", 32'(inst_valid), 32'd0);
    chk("stale_req",   32'(mem_req), 32'd1);
    chk("stale_addr",  mem_addr, 32'h0);

    // Redirect while 0x8 is outstanding, ack after 3 cycles
    mem_ack = 1'b1; mem_rdata = 32'hD000_0000;
    tick();
    mem_rdata = 32'hD000_0004;
    tick();
    mem_ack = 1'b0;
    chk("pre_disc_addr", mem_addr, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("disc_req",   32'(mem_req), 32'd1);
    chk("disc_addr",  mem_addr, 32'h8);
    chk("disc_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("disc_addr2", mem_addr, 32'h8);
    mem_ack = 1'b1; mem_rdata = 32'hD000_0008;
    tick();
    mem_ack = 1'b0;
    chk("drop_req",   32'(mem_req), 32'd0);
    chk("drop_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("new_addr",  mem_addr, 32'h100);
    chk("new_valid", 32'(inst_valid), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hD000_0100;
    tick();
    mem_ack = 1'b0;
    chk("new_head_valid", 32'(inst_valid), 32'd1);
    chk("new_head",       inst_out, 32'hD000_0100);
    chk("new_head_pc4",   inst_pc_plus_4, 32'h104);
    chk("new_next_addr",  mem_addr, 32'h104);

    // Drain, then ack into an empty queue with deq
    deq = 1'b1;
    tick();
    deq = 1'b0;
    chk("drain_valid", 32'(inst_valid), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h8C02_0004; deq = 1'b1;
    #1;
`ifdef PREFETCH_BYPASS_EN
    chk("byp_valid", 32'(inst_valid), 32'd1);
    chk("byp_out",   inst_out, 32'h8C02_0004);
`else
    chk("nobyp_valid", 32'(inst_valid), 32'd0);
`endif
    tick();
    mem_ack = 1'b0; deq = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    chk("byp_after_valid", 32'(inst_valid), 32'd0);
`else
    chk("nobyp_after_valid", 32'(inst_valid), 32'd1);
    chk("nobyp_after_out",   inst_out, 32'h8C02_0004);
    chk("nobyp_after_pc4",   inst_pc_plus_4, 32'h108);
`endif
    chk("byp_next_addr", mem_addr, 32'h108);

    // Second redirect in DISCARD only retargets fetch_pc; pc wraps at top of memory
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    chk("d2_addr", mem_addr, 32'h108);
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("d2_req",   32'(mem_req), 32'd1);
    chk("d2_addr2", mem_addr, 32'h108);
    chk("d2_valid", 32'(inst_valid), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    chk("d2_drop_req", 32'(mem_req), 32'd0);
    tick();
    chk("wrap_req_addr", mem_addr, 32'hFFFF_FFFC);
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    chk("wrap_valid",     32'(inst_valid), 32'd1);
    chk("wrap_out",       inst_out, 32'h2222_2222);
    chk("wrap_pc4",       inst_pc_plus_4, 32'h0);
    chk("wrap_next_addr", mem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
